// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a coherent output delay line.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module vga_timing_gen #(
    parameter int H_DISP     = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_DISP     = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter int H_POL      = 1,
    parameter int V_POL      = 1,
    parameter int PIPE_DELAY = 0,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          de,
    output logic          h_sync,
    output logic          v_sync,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_DISP + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISP + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int SW       = 2 * CW + 5;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic          H_ACT  = (H_POL != 0);
    localparam logic          V_ACT  = (V_POL != 0);
    // Stage record layout: {col, row, de, h_sync, v_sync, line_start, frame_start}
    localparam logic [SW-1:0] ST_RST = {{(2 * CW + 1){1'b0}}, ~H_ACT, ~V_ACT, 2'b00};

    if ((H_SYNC == 0) || (V_SYNC == 0)) begin : g_bad_sync
        $error("vga_timing_gen: H_SYNC and V_SYNC must be non-zero");
    end

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          hs_raw, vs_raw, de_raw;
    logic [SW-1:0] st0_d;
    logic [SW-1:0] pipe_q [PIPE_DELAY+1];

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == H_LAST) begin
            col_d = '0;
            row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_ce) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        hs_raw = (int'(col_q) >= HS_START) && (int'(col_q) < HS_END);
        vs_raw = (int'(row_q) >= VS_START) && (int'(row_q) < VS_END);
        de_raw = (int'(col_q) < H_DISP) && (int'(row_q) < V_DISP);
        st0_d  = {col_q, row_q, de_raw, hs_raw ~^ H_ACT, vs_raw ~^ V_ACT,
                  col_q == '0, (col_q == '0) && (row_q == '0)};
    end

    // pipe_q[0] is stage 0; the last entry drives the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= PIPE_DELAY; i++) pipe_q[i] <= ST_RST;
        end else if (pix_ce) begin
            pipe_q[0] <= st0_d;
            for (int unsigned i = 1; i <= PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {col, row, de, h_sync, v_sync, line_start, frame_start} = pipe_q[PIPE_DELAY];

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) frame_cnt_q <= '0;
        else if (pix_ce && frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; the next generation of the fixed 800x600 sync/porch chain.
- Produces h_sync and v_sync with porches applied, plus data-enable, pixel coordinates and frame/line strobes.
- All porch widths, sync widths and sync polarities are set by parameters.
- A parametrised output delay line aligns timing outputs with a downstream pixel pipeline (pong renderer, rgb mux).

Parameters:
- H_DISP, 800, active columns
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync pulse width
- H_BP, 64, horizontal back porch
- V_DISP, 600, active rows
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync pulse width
- V_BP, 23, vertical back porch
- H_POL, 1, h_sync active level (1 = active-high)
- V_POL, 1, v_sync active level
- PIPE_DELAY, 0, extra pixel-clock stages on all outputs (0..15)
- CW, 11, width of col/row outputs; must hold H_TOTAL-1 and V_TOTAL-1

Derived:
- H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP (default 1040)
- V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP (default 666)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_ce  in  1  pixel clock enable; all state advances only when high
- col  out  CW  current column, 0..H_TOTAL-1
- row  out  CW  current row, 0..V_TOTAL-1
- de  out  1  high when col < H_DISP and row < V_DISP
- h_sync  out  1  horizontal sync, polarity H_POL
- v_sync  out  1  vertical sync, polarity V_POL
- line_start  out  1  one-ce pulse when col == 0
- frame_start  out  1  one-ce pulse when col == 0 and row == 0
- frame_cnt  out  16  frames completed (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: internal col/row counters = 0; all delay stages flushed. Outputs during reset and for the first clk after release: col = 0, row = 0, de = 0, h_sync = !H_POL, v_sync = !V_POL, line_start = 0, frame_start = 0, frame_cnt = 0.
- Counter advance (on pix_ce):
  - col increments; at H_TOTAL-1 it wraps to 0.
  - row increments only on a col wrap; at V_TOTAL-1 together with a col wrap it wraps to 0.
- pix_ce low: counters, stage-0 registers and delay line all hold their values.
- Stage 0 (registered from counters on pix_ce):
  - hs_raw = (col >= H_DISP+H_FP) and (col < H_DISP+H_FP+H_SYNC)
  - vs_raw = (row >= V_DISP+V_FP) and (row < V_DISP+V_FP+V_SYNC)
  - h_sync = hs_raw XNOR H_POL; v_sync = vs_raw XNOR V_POL
  - vs_raw depends on row only, so v_sync changes only at col 0.
- Delay line:
  - PIPE_DELAY stages, shifting only on pix_ce.
  - col, row, de, h_sync, v_sync and both strobes travel together; outputs are mutually coherent every cycle.
- Latency: counter value N appears on outputs 1 + PIPE_DELAY pix_ce-qualified clocks later. With PIPE_DELAY = 0 the stage-0 register drives the outputs.
- Strobes: asserted for exactly one pix_ce period. With pix_ce held high this is one clk.
- Reset mid-frame: next clk outputs the reset values; counting restarts at (0,0) and the first frame_start appears 1 + PIPE_DELAY ce-ticks after release.
- Elaboration: widths are the parameter values. A zero-width porch is legal, with the sync window starting immediately after display. H_SYNC = 0 or V_SYNC = 0 is illegal and trips a $error.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN
- Defined: frame_cnt increments by 1 (wrapping at 65535 to 0) on the same ce-tick on which the output-side frame_start is high. It is reset to 0. It lets the pong logic pace ball movement per frame.
- Undefined: frame_cnt is tied to 0 and no counter is synthesised.

Test Plan:
- Defaults, pix_ce = 1, rst_n low 4 clks then high -> first frame_start 1 clk after release; h_sync high at col 856..975 only; 1040 clks between line_start pulses; 692,640 clks between frame_start pulses.
- Defaults -> v_sync high for rows 637..642 exactly (6 lines = 6,240 clks); de high 800 clks per line for rows 0..599; de count per frame = 480,000.
- H_POL = 0, V_POL = 0 -> h_sync/v_sync are the bitwise inverses of the default run; idle level after reset = 1.
- PIPE_DELAY = 3, pix_ce toggling 1-0-1-0 -> all outputs lag the PIPE_DELAY = 0 reference by exactly 3 ce-ticks (6 clks); outputs hold stable on ce-low cycles.
- rst_n pulsed low 1 clk at col 500, row 300 -> next clk col = 0, row = 0, de = 0, syncs inactive; the full frame timing then repeats from the top.
- VGA_TIMING_FRAME_CNT_EN defined, H_DISP=4, H_FP=1, H_SYNC=1, H_BP=1, V_DISP=2, V_FP=1, V_SYNC=1, V_BP=1 -> frame period 35 clks; frame_cnt = 3 after 3 frame_start pulses; wrap 65535 -> 0 checked via force.
